// File: rtl/mult_div_unit.sv
// Multicycle 32-bit MULT/DIV unit: radix-2 Booth multiply, restoring divide, HI/LO results.
// Define MULTDIV_UNSIGNED_EN to add MULTU/DIVU selected by op[1].
`timescale 1ns/1ps
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d, m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d, hi_q, hi_d, lo_q, lo_d;
    logic             q1_q, q1_d, div_q, div_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             corr_q, corr_d, dz_q, dz_d;

    logic             uns;
`ifdef MULTDIV_UNSIGNED_EN
    assign uns = op[1];
`else
    logic unused_op1;
    assign unused_op1 = op[1];
    assign uns = 1'b0;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = !uns && a[WIDTH-1];
    assign b_neg = !uns && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Booth sum is one bit wider than the accumulator so unsigned multiplicands never overflow
    logic [WIDTH+1:0] bsum;
    always_comb begin
        case ({q_q[0], q1_q})
            2'b10:   bsum = {p_q[WIDTH], p_q} - {m_q[WIDTH], m_q};
            2'b01:   bsum = {p_q[WIDTH], p_q} + {m_q[WIDTH], m_q};
            default: bsum = {p_q[WIDTH], p_q};
        endcase
    end

    logic [WIDTH:0]   rsh;
    logic [WIDTH+1:0] rdiff;
    assign rsh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign rdiff = {1'b0, rsh} - {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        corr_d  = corr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = CW'(WIDTH);
                    div_d  = op[0];
                    p_d    = '0;
                    q1_d   = 1'b0;
                    dz_d   = 1'b0;
                    qneg_d = 1'b0;
                    rneg_d = 1'b0;
                    corr_d = 1'b0;
                    state_d = S_RUN;
                    if (op[0]) begin
                        q_d    = a_mag;
                        m_d    = {1'b0, b_mag};
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        if (b == '0) begin
                            dz_d    = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        q_d    = b;
                        m_d    = {!uns && a[WIDTH-1], a};
                        // Booth treats b as signed; add a<<WIDTH back for unsigned b
                        corr_d = uns && b[WIDTH-1];
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (div_q) begin
                    if (!rdiff[WIDTH+1]) begin
                        p_d = rdiff[WIDTH:0];
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = rsh;
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_d  = bsum[WIDTH+1:1];
                    q_d  = {bsum[0], q_q[WIDTH-1:1]};
                    q1_d = q_q[0];
                end
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    lo_d = qneg_q ? -q_q : q_q;
                    hi_d = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                end else begin
                    hi_d = p_q[WIDTH-1:0] + (corr_q ? m_q[WIDTH-1:0] : '0);
                    lo_d = q_q;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            corr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            corr_q  <= corr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = done && dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus random MULT/DIV against a longint model.
`timescale 1ns/1ps
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl, output logic dz);
        bit     u;
        longint sx, sy, p, q, r;
`ifdef MULTDIV_UNSIGNED_EN
        u = o[1];
`else
        u = 1'b0;
`endif
        sx = u ? longint'(x) : longint'(signed'(x));
        sy = u ? longint'(y) : longint'(signed'(y));
        dz = 1'b0;
        if (!o[0]) begin
            p = sx * sy;
            {rh, rl} = p;
        end else if (y == '0) begin
            rh = m_hi;
            rl = m_lo;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            rh = r[W-1:0];
            rl = q[W-1:0];
        end
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy=%0b done=%0b never cleared", busy, done);
        end
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
        if (push) begin
            model(o, x, y, e.hi, e.lo, e.dz);
            e.due = e.dz ? cyc : cyc + W + 1;
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results never appeared", sb_q.size());
            sb_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("div_zero", div_zero, e.dz);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    logic [W-1:0] sp[6];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        sp[0] = 32'h8000_0000;
        sp[1] = 32'hFFFF_FFFF;
        sp[2] = 32'h7FFF_FFFF;
        sp[3] = 32'h0000_0001;
        sp[4] = 32'h0000_0000;
        sp[5] = 32'hFFFF_FFF9;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;

        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1);
        wait_drain();
        check("mult7x-3_hi", hi, 32'hFFFF_FFFF);
        check("mult7x-3_lo", lo, 32'hFFFF_FFEB);

        issue(2'b00, 32'h0001_2345, 32'h0006_789A, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", busy, 0);

        issue(2'b01, 32'hFFFF_FFF9, 32'd2, 1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            check($sformatf("div_busy_c%0d", k), busy, (k <= 33) ? 1 : 0);
        end
        wait_drain();
        check("div-7/2_lo", lo, 32'hFFFF_FFFD);
        check("div-7/2_hi", hi, 32'hFFFF_FFFF);

        issue(2'b01, 32'd5, 32'd0, 1);
        wait_drain();
        check("divzero_hi", hi, 32'hFFFF_FFFF);
        check("divzero_lo", lo, 32'hFFFF_FFFD);

        issue(2'b01, 32'd100, 32'd7, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        a = 32'd3;
        b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        check("ignored_start_lo", lo, 32'd14);
        check("ignored_start_hi", hi, 32'd2);

        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_drain();
        check("minint_div_lo", lo, 32'h8000_0000);
        check("minint_div_hi", hi, 32'h0);

        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_drain();
`ifdef MULTDIV_UNSIGNED_EN
        check("multu_hi", hi, 32'hFFFF_FFFE);
`else
        check("multu_hi", hi, 32'h0);
`endif
        check("multu_lo", lo, 32'h1);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : W'($urandom);
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 3) == 0) y = W'($urandom_range(1, 50));
            issue(2'($urandom), x, y, 1);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
